// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative AES (Inv)MixColumns over a 4x32 row-organised state,
// COLS_PER_CYCLE columns per clock, valid/ready on both sides, last-round bypass.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INVERSE        = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        last_round,
    input  logic [31:0] row1,
    input  logic [31:0] row2,
    input  logic [31:0] row3,
    input  logic [31:0] row4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] row1_out,
    output logic [31:0] row2_out,
    output logic [31:0] row3_out,
    output logic [31:0] row4_out
);
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e            state_q, state_d;
    logic [1:0]        col_q, col_d;
    logic [2:0]        col_nxt;
    logic              last_q, last_d;
    logic [3:0][31:0]  rows_q, rows_d, out_q, out_d, mixed;
    logic [31:0]       mix_w;
    logic              accept;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Any coefficient in both matrices is a sum of 1, 2, 4 and 8 times x.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xt(x);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[0] ? x : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    // Circulant matrix: output row i uses the first row rotated right by i.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [15:0] m;
        logic [7:0]  o;
        m = INVERSE ? 16'hebd9 : 16'h2311;
        mix_col = '0;
        for (int i = 0; i < 4; i++) begin
            o = '0;
            for (int j = 0; j < 4; j++)
                o ^= gmul(c[31-8*j -: 8], m[15-4*((j-i)&3) -: 4]);
            mix_col[31-8*i -: 8] = o;
        end
    endfunction

    always_comb begin
        mixed = rows_q;
        mix_w = '0;
        for (int c = 0; c < 4; c++) begin
            if (!last_q && c >= int'(col_q) && c < int'(col_q) + COLS_PER_CYCLE) begin
                mix_w = mix_col({rows_q[0][31-8*c -: 8], rows_q[1][31-8*c -: 8],
                                 rows_q[2][31-8*c -: 8], rows_q[3][31-8*c -: 8]});
                for (int r = 0; r < 4; r++)
                    mixed[r][31-8*c -: 8] = mix_w[31-8*r -: 8];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        rows_d    = rows_q;
        last_d    = last_q;
        out_d     = out_q;
        col_nxt   = {1'b0, col_q} + 3'(COLS_PER_CYCLE);
        in_ready  = rst_n && (state_q == IDLE || (state_q == DONE && out_ready));
        out_valid = state_q == DONE;
        accept    = in_valid && in_ready;
        if (state_q == BUSY) begin
            rows_d = mixed;
            col_d  = col_nxt[1:0];
            if (col_nxt[2]) begin
                state_d = DONE;
                out_d   = mixed;
            end
        end else if (accept) begin
            rows_d  = {row4, row3, row2, row1};
            last_d  = last_round;
            col_d   = 2'd0;
            state_d = BUSY;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            rows_q  <= '0;
            last_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            rows_q  <= rows_d;
            last_q  <= last_d;
            out_q   <= out_d;
        end
    end

    assign row1_out = out_q[0];
    assign row2_out = out_q[1];
    assign row3_out = out_q[2];
    assign row4_out = out_q[3];
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed checks of forward/inverse MixColumns, bypass, backpressure and reset.
module tb_mix_columns_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv[3], ir[3], lr[3], ov[3], ordy[3];
    logic [31:0] ri[3][4], ro[3][4];
    int total = 0;
    int bad = 0;

    localparam logic [127:0] FIPS_IN  = 128'hdbf201c6_130a01c6_532201c6_455c01c6;
    localparam logic [127:0] FIPS_MIX = 128'h8e9f01c6_4ddc01c6_a15801c6_bc9d01c6;
    localparam logic [127:0] D_IN     = 128'hd4d4d4d4_d4d4d4d4_d4d4d4d4_d5d5d5d5;
    localparam logic [127:0] D_MIX    = 128'hd5d5d5d5_d5d5d5d5_d7d7d7d7_d6d6d6d6;

    mix_columns_seq #(.COLS_PER_CYCLE(1), .INVERSE(1'b0)) u_f1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .last_round(lr[0]),
        .row1(ri[0][0]), .row2(ri[0][1]), .row3(ri[0][2]), .row4(ri[0][3]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .row1_out(ro[0][0]), .row2_out(ro[0][1]), .row3_out(ro[0][2]), .row4_out(ro[0][3]));

    mix_columns_seq #(.COLS_PER_CYCLE(1), .INVERSE(1'b1)) u_i1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .last_round(lr[1]),
        .row1(ri[1][0]), .row2(ri[1][1]), .row3(ri[1][2]), .row4(ri[1][3]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .row1_out(ro[1][0]), .row2_out(ro[1][1]), .row3_out(ro[1][2]), .row4_out(ro[1][3]));

    mix_columns_seq #(.COLS_PER_CYCLE(4), .INVERSE(1'b1)) u_i4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .last_round(lr[2]),
        .row1(ri[2][0]), .row2(ri[2][1]), .row3(ri[2][2]), .row4(ri[2][3]),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .row1_out(ro[2][0]), .row2_out(ro[2][1]), .row3_out(ro[2][2]), .row4_out(ro[2][3]));

    function automatic logic [127:0] outs(input int d);
        return {ro[d][0], ro[d][1], ro[d][2], ro[d][3]};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input int d, input logic [127:0] v, input logic l);
        iv[d] = 1'b1;
        {ri[d][0], ri[d][1], ri[d][2], ri[d][3]} = v;
        lr[d] = l;
    endtask

    task automatic send(input int d, input logic [127:0] v, input logic l);
        drive(d, v, l);
        #1 check("in_ready_idle", 128'(ir[d]), 128'(1));
        tick();
        iv[d] = 1'b0;
    endtask

    task automatic expect_out(input int d, input string tag, input int lat, input logic [127:0] v);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ov[d] && n < 20);
        check({tag, "_latency"}, 128'(n), 128'(lat));
        check({tag, "_data"}, outs(d), v);
    endtask

    task automatic take(input int d);
        ordy[d] = 1'b1;
        tick();
        ordy[d] = 1'b0;
        check("out_valid_cleared", 128'(ov[d]), 128'(0));
    endtask

    initial begin
        int seen;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            lr[d] = 1'b0;
            ordy[d] = 1'b0;
            for (int r = 0; r < 4; r++) ri[d][r] = '0;
        end
        tick();
        tick();
        check("rst_out_valid", 128'(ov[0]), 128'(0));
        check("rst_in_ready", 128'(ir[0]), 128'(0));
        check("rst_rows", outs(0), 128'(0));
        rst_n = 1'b1;
        #1 check("in_ready_after_rst", 128'(ir[0]), 128'(1));

        send(0, FIPS_IN, 1'b0);
        expect_out(0, "fwd_fips", 4, FIPS_MIX);

        drive(0, D_IN, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_out_valid", 128'(ov[0]), 128'(1));
            check("bp_in_ready", 128'(ir[0]), 128'(0));
            check("bp_rows", outs(0), FIPS_MIX);
        end
        ordy[0] = 1'b1;
        #1 check("bp_in_ready_release", 128'(ir[0]), 128'(1));
        tick();
        ordy[0] = 1'b0;
        iv[0] = 1'b0;
        check("bp_out_valid_drop", 128'(ov[0]), 128'(0));
        check("bp_rows_held", outs(0), FIPS_MIX);
        expect_out(0, "bp_second", 4, D_MIX);
        take(0);

        send(0, FIPS_IN, 1'b1);
        expect_out(0, "last_round", 4, FIPS_IN);
        take(0);

        send(0, FIPS_IN, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", 128'(ov[0]), 128'(0));
        check("midrst_rows", outs(0), 128'(0));
        rst_n = 1'b1;
        #1 check("midrst_in_ready", 128'(ir[0]), 128'(1));
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ov[0]) seen++;
        end
        check("midrst_no_result", 128'(seen), 128'(0));
        send(0, FIPS_IN, 1'b0);
        expect_out(0, "midrst_fresh", 4, FIPS_MIX);
        take(0);

        send(1, FIPS_MIX, 1'b0);
        expect_out(1, "inv_c1", 4, FIPS_IN);
        take(1);

        send(2, FIPS_MIX, 1'b0);
        expect_out(2, "inv_c4", 1, FIPS_IN);
        take(2);

        send(2, D_IN, 1'b1);
        expect_out(2, "inv_c4_last", 1, D_IN);
        take(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
